// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: holds the instruction under decode, extracts
// the immediate field and opcode, runs both handshakes, inserts load-use
// bubbles, applies flushes and counts hazard-stall cycles.
// Ports: clk/rst; IF side if_valid/if_instr/if_pc/id_ready;
// EX side id_valid/ex_ready/id_instr/id_pc/id_opcode/id_imm_in/id_illegal;
// hazard inputs ex_valid/ex_is_load/ex_rd; flush; stall_cnt.
module id_stage_ctrl #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid,
  input  logic [XLEN-1:0]        if_instr,
  input  logic [XLEN-1:0]        if_pc,
  output logic                   id_ready,
  output logic                   id_valid,
  input  logic                   ex_ready,
  output logic [XLEN-1:0]        id_instr,
  output logic [XLEN-1:0]        id_pc,
  output logic [6:0]             id_opcode,
  output logic [19:0]            id_imm_in,
  output logic                   id_illegal,
  input  logic                   ex_valid,
  input  logic                   ex_is_load,
  input  logic [4:0]             ex_rd,
  input  logic                   flush,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        instr_q, instr_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] i;
  logic [6:0]  op;
  logic        rs1_used;
  logic        rs2_used;
  logic        legal;
  logic [19:0] imm;
  logic        held;
  logic        hazard;
  logic        fire;
  logic        accept;

  assign i    = instr_q[31:0];
  assign op   = i[6:0];
  assign held = (state_q != EMPTY);

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    legal    = 1'b1;
    imm      = '0;
    unique case (op)
      OP_LOAD, OP_IMM, OP_JALR: begin
        rs1_used = 1'b1;
        imm      = {{8{i[31]}}, i[31:20]};
      end
      OP_STORE: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm      = {{8{i[31]}}, i[31:25], i[11:7]};
      end
      OP_BR: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm      = {{8{i[31]}}, i[31], i[7], i[30:25], i[11:8]};
      end
      OP_LUI, OP_AUIPC: imm = i[31:12];
      OP_JAL:   imm = {i[31], i[19:12], i[20], i[30:21]};
      OP_REG: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      default:  legal = 1'b0;
    endcase
  end

  // x0 is never a real producer, so a load into it cannot stall decode.
  assign hazard = held && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                  ((rs1_used && (ex_rd == i[19:15])) ||
                   (rs2_used && (ex_rd == i[24:20])));

  assign id_valid = held && !hazard && !flush;
  assign fire     = id_valid && ex_ready;
  assign id_ready = !flush && (!held || fire);
  assign accept   = if_valid && id_ready;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d = FULL;
      instr_d = if_instr;
      pc_d    = if_pc;
    end else if (fire) begin
      state_d = EMPTY;
    end else if (hazard) begin
      state_d = STALL;
      if (cnt_q != '1) cnt_d = cnt_q + STALL_CNT_W'(1);
    end else if (state_q == STALL) begin
      state_d = FULL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      instr_q <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign id_instr   = instr_q;
  assign id_pc      = pc_q;
  assign id_opcode  = op;
  // Stale instruction bits must not leak into the extender when empty.
  assign id_imm_in  = held ? imm : 20'd0;
  assign id_illegal = held && !legal;
  assign stall_cnt  = cnt_q;

endmodule

// File: doc/id_stage_ctrl.md
Name: id_stage_ctrl

Overview:
- Decode-stage controller between the IF/ID boundary and the ID/EX boundary of the RV32 core.
- Holds the instruction under decode and extracts the immediate bit-field (id_imm_in) and opcode (id_opcode) that drive the immediate sign extender.
- Runs the valid/ready handshake on both sides, inserts load-use bubbles and applies branch/jump flushes.
- Counts hazard-stall cycles for performance debug.

Parameters:
- XLEN, 32, instruction and PC width.
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  XLEN  fetched instruction.
- if_pc  in  XLEN  PC of if_instr.
- id_ready  out  1  decode can accept from fetch this cycle.
- id_valid  out  1  decoded instruction offered to EX.
- ex_ready  in  1  EX accepts this cycle.
- id_instr  out  XLEN  held instruction.
- id_pc  out  XLEN  held PC.
- id_opcode  out  7  id_instr[6:0], to sign extender.
- id_imm_in  out  20  immediate field, to sign extender.
- id_illegal  out  1  held opcode not supported; qualified by id_valid.
- ex_valid  in  1  EX holds a valid instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- flush  in  1  redirect from branch/jump resolution.
- stall_cnt  out  STALL_CNT_W  hazard-stall cycles since reset.

Behaviour:
- Reset (async, rst=1):
  - state=EMPTY, id_instr=0, id_pc=0, stall_cnt=0.
  - Outputs therefore: id_valid=0, id_ready=1, id_imm_in=0, id_opcode=0, id_illegal=0.
- States:
  - EMPTY: no instruction held.
  - FULL: instruction held, no hazard.
  - STALL: instruction held, load-use hazard.
- hazard (combinational):
  - Requires state!=EMPTY, ex_valid=1, ex_is_load=1 and ex_rd!=0.
  - And either: (rs1_used and ex_rd==id_instr[19:15]) or (rs2_used and ex_rd==id_instr[24:20]).
  - rs1_used for opcodes 0110011, 0000011, 0010011, 0100011, 1100011, 1100111.
  - rs2_used for opcodes 0110011, 0100011, 1100011.
- Handshake outputs:
  - id_valid = (state!=EMPTY) & !hazard & !flush.
  - fire = id_valid & ex_ready.
  - id_ready = !flush & ((state==EMPTY) | fire).
  - accept = if_valid & id_ready.
- Transitions (priority order):
  - flush=1 -> EMPTY. A concurrent if_valid is dropped; stall_cnt is not incremented.
  - accept -> capture if_instr/if_pc; next state is FULL. This covers accept from EMPTY and back-to-back accept with fire.
  - fire & !accept -> EMPTY.
  - hazard -> STALL. Registers are held and stall_cnt increments, saturating at all-ones.
  - STALL & !hazard -> FULL.
  - Otherwise, hold state and registers.
- Latency: an instruction accepted at edge N is offered to EX (id_valid=1) in cycle N+1 when there is no hazard. Throughput is 1 instruction/cycle.
- id_opcode = id_instr[6:0]. id_imm_in is selected combinationally from id_instr (i = id_instr):
  - 0000011, 0010011: {8{i[31]}, i[31:20]}.
  - 1100111: {8{i[31]}, i[31:20]}. Bits [19:12] are sign copies, so 20-bit extension equals 12-bit extension.
  - 0100011: {8{i[31]}, i[31:25], i[11:7]}.
  - 1100011: {8{i[31]}, i[31], i[7], i[30:25], i[11:8]}.
  - 0110111, 0010111: i[31:12].
  - 1101111: {i[31], i[19:12], i[20], i[30:21]}.
  - 0110011: 0.
  - Any other opcode: 0, and id_illegal=1 while state!=EMPTY.
- Illegal instructions still handshake normally. EX owns the trap.
- While state==EMPTY, id_imm_in is driven to 0 regardless of the stale id_instr.
- stall_cnt is never cleared except by rst.
- Reset mid-stall returns immediately to the reset values above, with no handshake completion.

Test Plan:
- Stream: if_valid=1 and ex_ready=1 for 4 cycles, instrs addi x1,x0,-1 (0xFFF00093), sw, beq, lui -> id_valid=1 from cycle 2 and one instruction per cycle.
  - addi: id_imm_in=0xFFFFF.
  - lui 0x12345 (0x123450B7): id_imm_in=0x12345.
  - No stalls; stall_cnt=0.
- Backpressure: ex_ready=0 for 3 cycles with an instruction held -> id_ready=0 and id_instr/id_pc stable. On ex_ready=1, fire and accept occur the same cycle.
- Load-use: ex_valid=1, ex_is_load=1, ex_rd=5 with held add x6,x5,x7 -> id_valid=0 and state=STALL for 2 cycles, stall_cnt=2. After hazard clears, id_valid=1 the next cycle.
  - Same check with ex_rd=0 -> no stall.
- Flush: flush=1 while FULL and if_valid=1 -> id_ready=0 and id_valid=0 that cycle; next cycle state=EMPTY and the fetched instruction is not captured.
- Illegal/JAL: held opcode 0x7F -> id_illegal=1, id_imm_in=0.
  - jal x0 (0x0040006F) -> id_imm_in=0x00002.
  - jalr x1,4(x2) (0x004100E7) -> id_imm_in=0x00004.
- Async reset: assert rst mid-STALL, between clock edges -> all outputs take their reset values immediately; stall_cnt=0.
